// File: rtl/fir_input_stage.sv
// Input stage of the FIR datapath: sample FIFO, tapped delay line and
// coefficient shift bank, with a 4-wide group mux feeding the multipliers.
module fir_input_stage #(
    parameter int unsigned DW    = 24,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned NTAPS = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              PushIn,
    input  logic [DW-1:0]     DataIn,
    input  logic              PushCoef,
    input  logic [DW-1:0]     CoefIn,
    input  logic              fifoPullOut,
    input  logic [1:0]        multiplier_mux_sel,
    output logic              fifo_empty,
    output logic              fifo_full,
    output logic              overflow,
    output logic              coef_ready,
    output logic [4*DW-1:0]   sample_group,
    output logic [4*DW-1:0]   coef_group
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned CW      = $clog2(NTAPS + 1);
    localparam int unsigned NGROUPS = 3;
    localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] LOAD_DONE = CW'(NTAPS);

    logic [AW:0]    wptr;
    logic [AW:0]    rptr;
    logic [AW:0]    count;
    logic [CW-1:0]  load_cnt;
    logic           ovf_q;
    logic [DW-1:0]  mem  [DEPTH];
    logic [DW-1:0]  tap  [NTAPS];
    logic [DW-1:0]  coef [NTAPS];

    logic           full;
    logic           ready;
    logic           pull_ok;
    logic           push_ok;

    logic [4*DW-1:0] tap_grp  [NGROUPS];
    logic [4*DW-1:0] coef_grp [NGROUPS];

    // Accept decode: a pull needs data and a complete coefficient bank; a
    // push into a full FIFO is only accepted when a pull frees a slot.
    assign full    = (count == FULL_CNT);
    assign ready   = (load_cnt == LOAD_DONE);
    assign pull_ok = fifoPullOut && (count != '0) && ready;
    assign push_ok = PushIn && (!full || pull_ok);

    assign fifo_empty = (count == '0) || !ready;
    assign fifo_full  = full;
    assign overflow   = ovf_q;
    assign coef_ready = ready;

    // FIFO pointers, occupancy count and sticky overflow flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + (AW+1)'(1);
            end
            if (pull_ok) begin
                rptr <= rptr + (AW+1)'(1);
            end
            if (push_ok && !pull_ok) begin
                count <= count + (AW+1)'(1);
            end else if (pull_ok && !push_ok) begin
                count <= count - (AW+1)'(1);
            end
            if (PushIn && full && !pull_ok) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // FIFO storage; contents are meaningless until the pointers say otherwise
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr[AW-1:0]] <= DataIn;
        end
    end

    // Delay line: each accepted pull moves the FIFO head into the newest tap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NTAPS; k++) begin
                tap[k] <= '0;
            end
        end else if (pull_ok) begin
            for (int k = NTAPS - 1; k > 0; k--) begin
                tap[k] <= tap[k-1];
            end
            tap[0] <= mem[rptr[AW-1:0]];
        end
    end

    // Coefficient bank keeps shifting after it is full; only the counter saturates
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_cnt <= '0;
            for (int k = 0; k < NTAPS; k++) begin
                coef[k] <= '0;
            end
        end else if (PushCoef) begin
            for (int k = NTAPS - 1; k > 0; k--) begin
                coef[k] <= coef[k-1];
            end
            coef[0] <= CoefIn;
            if (load_cnt != LOAD_DONE) begin
                load_cnt <= load_cnt + CW'(1);
            end
        end
    end

    // Pack each group of four taps/coefficients, lowest index in the low lane
    for (genvar g = 0; g < NGROUPS; g++) begin : g_pack
        for (genvar k = 0; k < 4; k++) begin : g_lane
            assign tap_grp[g][k*DW +: DW]  = tap[4*g + k];
            assign coef_grp[g][k*DW +: DW] = coef[4*g + k];
        end
    end

    // Group select toward the multipliers; select value 3 yields zeros
    always_comb begin
        sample_group = '0;
        coef_group   = '0;
        case (multiplier_mux_sel)
            2'd0: begin
                sample_group = tap_grp[0];
                coef_group   = coef_grp[0];
            end
            2'd1: begin
                sample_group = tap_grp[1];
                coef_group   = coef_grp[1];
            end
            2'd2: begin
                sample_group = tap_grp[2];
                coef_group   = coef_grp[2];
            end
            default: begin
                sample_group = '0;
                coef_group   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_fir_input_stage.sv
// Directed bench for fir_input_stage: coefficient load, FIFO full/empty
// corner cases, delay-line ordering, group mux and mid-stream reset.
module tb_fir_input_stage;

    localparam int unsigned DW = 24;

    logic            clk = 1'b0;
    logic            reset;
    logic            PushIn;
    logic [DW-1:0]   DataIn;
    logic            PushCoef;
    logic [DW-1:0]   CoefIn;
    logic            fifoPullOut;
    logic [1:0]      multiplier_mux_sel;
    logic            fifo_empty;
    logic            fifo_full;
    logic            overflow;
    logic            coef_ready;
    logic [4*DW-1:0] sample_group;
    logic [4*DW-1:0] coef_group;

    int checks   = 0;
    int failures = 0;

    fir_input_stage #(.DW(DW), .DEPTH(8), .NTAPS(12)) dut (
        .clk                (clk),
        .reset              (reset),
        .PushIn             (PushIn),
        .DataIn             (DataIn),
        .PushCoef           (PushCoef),
        .CoefIn             (CoefIn),
        .fifoPullOut        (fifoPullOut),
        .multiplier_mux_sel (multiplier_mux_sel),
        .fifo_empty         (fifo_empty),
        .fifo_full          (fifo_full),
        .overflow           (overflow),
        .coef_ready         (coef_ready),
        .sample_group       (sample_group),
        .coef_group         (coef_group)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [4*DW-1:0] pack4(input int a3, input int a2, input int a1, input int a0);
        return {DW'(a3), DW'(a2), DW'(a1), DW'(a0)};
    endfunction

    // One clock; inputs change and outputs are sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int v);
        PushIn = 1'b1;
        DataIn = DW'(v);
        tick();
        PushIn = 1'b0;
    endtask

    task automatic pull();
        fifoPullOut = 1'b1;
        tick();
        fifoPullOut = 1'b0;
    endtask

    task automatic load_coefs();
        for (int i = 1; i <= 12; i++) begin
            PushCoef = 1'b1;
            CoefIn   = DW'(i);
            tick();
            if (i == 11) check("coef_ready_at_11", 128'(coef_ready), 128'(0));
        end
        PushCoef = 1'b0;
        check("coef_ready_at_12", 128'(coef_ready), 128'(1));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_empty"},  128'(fifo_empty),   128'(1));
        check({tag, "_full"},   128'(fifo_full),    128'(0));
        check({tag, "_ovf"},    128'(overflow),     128'(0));
        check({tag, "_ready"},  128'(coef_ready),   128'(0));
        check({tag, "_sgrp"},   128'(sample_group), 128'(0));
        check({tag, "_cgrp"},   128'(coef_group),   128'(0));
    endtask

    initial begin
        reset = 1'b1;
        PushIn = 1'b0;
        DataIn = '0;
        PushCoef = 1'b0;
        CoefIn = '0;
        fifoPullOut = 1'b0;
        multiplier_mux_sel = 2'd0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check_reset_state("rst");

        // Sample pushed before coefficients: hidden and unpullable
        push(5);
        check("pre_coef_empty", 128'(fifo_empty), 128'(1));
        pull();
        check("pre_coef_pull_tap0", 128'(sample_group), 128'(0));
        check("pre_coef_pull_empty", 128'(fifo_empty), 128'(1));

        load_coefs();
        check("post_coef_empty", 128'(fifo_empty), 128'(0));
        multiplier_mux_sel = 2'd0; #1;
        check("coef_sel0", 128'(coef_group), 128'(pack4(9, 10, 11, 12)));
        multiplier_mux_sel = 2'd1; #1;
        check("coef_sel1", 128'(coef_group), 128'(pack4(5, 6, 7, 8)));
        multiplier_mux_sel = 2'd2; #1;
        check("coef_sel2", 128'(coef_group), 128'(pack4(1, 2, 3, 4)));
        multiplier_mux_sel = 2'd0; #1;

        pull();
        check("pull5_tap0", 128'(sample_group[DW-1:0]), 128'(5));
        check("pull5_empty", 128'(fifo_empty), 128'(1));

        // Fill, overflow on the 9th push, drain in order
        for (int i = 1; i <= 8; i++) push(i);
        check("fill_full", 128'(fifo_full), 128'(1));
        check("fill_no_ovf", 128'(overflow), 128'(0));
        push(9);
        check("ovf_set", 128'(overflow), 128'(1));
        check("ovf_full", 128'(fifo_full), 128'(1));
        for (int i = 1; i <= 8; i++) begin
            pull();
            check($sformatf("drain_tap0_%0d", i), 128'(sample_group[DW-1:0]), 128'(i));
        end
        check("drain_empty", 128'(fifo_empty), 128'(1));
        check("drain_taps", 128'(sample_group), 128'(pack4(5, 6, 7, 8)));

        // Full FIFO with simultaneous push and pull keeps count at DEPTH
        for (int i = 21; i <= 28; i++) push(i);
        PushIn = 1'b1;
        DataIn = DW'(9);
        fifoPullOut = 1'b1;
        tick();
        PushIn = 1'b0;
        fifoPullOut = 1'b0;
        check("fullpp_tap0", 128'(sample_group[DW-1:0]), 128'(21));
        check("fullpp_full", 128'(fifo_full), 128'(1));
        for (int i = 22; i <= 28; i++) begin
            pull();
            check($sformatf("fullpp_tap0_%0d", i), 128'(sample_group[DW-1:0]), 128'(i));
        end
        pull();
        check("fullpp_last9", 128'(sample_group[DW-1:0]), 128'(9));
        check("fullpp_empty", 128'(fifo_empty), 128'(1));

        // Empty FIFO with simultaneous push and pull: no fall-through
        PushIn = 1'b1;
        DataIn = DW'(7);
        fifoPullOut = 1'b1;
        tick();
        PushIn = 1'b0;
        fifoPullOut = 1'b0;
        check("emptypp_tap0", 128'(sample_group[DW-1:0]), 128'(9));
        check("emptypp_nonempty", 128'(fifo_empty), 128'(0));
        pull();
        check("emptypp_pull7", 128'(sample_group[DW-1:0]), 128'(7));
        check("emptypp_empty", 128'(fifo_empty), 128'(1));

        // Stream 1..12 through the delay line and inspect each group
        for (int i = 1; i <= 12; i++) begin
            push(i);
            pull();
        end
        multiplier_mux_sel = 2'd0; #1;
        check("stream_sel0", 128'(sample_group), 128'(pack4(9, 10, 11, 12)));
        multiplier_mux_sel = 2'd1; #1;
        check("stream_sel1", 128'(sample_group), 128'(pack4(5, 6, 7, 8)));
        multiplier_mux_sel = 2'd2; #1;
        check("stream_sel2", 128'(sample_group), 128'(pack4(1, 2, 3, 4)));
        multiplier_mux_sel = 2'd3; #1;
        check("sel3_sgrp", 128'(sample_group), 128'(0));
        check("sel3_cgrp", 128'(coef_group), 128'(0));
        multiplier_mux_sel = 2'd0; #1;
        check("ovf_sticky", 128'(overflow), 128'(1));

        // Mid-stream reset: asynchronous clear, pushes during reset ignored
        push(31);
        push(32);
        PushIn = 1'b1;
        DataIn = DW'(33);
        reset = 1'b1;
        #1;
        check_reset_state("async_rst");
        tick();
        tick();
        PushIn = 1'b0;
        reset = 1'b0;
        tick();
        check_reset_state("mid_rst");
        load_coefs();
        check("rst_fifo_cleared", 128'(fifo_empty), 128'(1));
        check("rst_full_cleared", 128'(fifo_full), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
